// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test_monitor run-control block.
// Benches import the same END_PC and MAX_CYCLES defaults.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  localparam logic [63:0] DEF_END_PC     = 64'h0000_0000_0000_001c;
  localparam int unsigned DEF_MAX_CYCLES = 10000000;

  function automatic logic is_busy(input mon_state_e s);
    return (s == RUN) || (s == CHECK);
  endfunction

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// The count sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/test_monitor.sv
// Run-control and pass/fail monitor for the RV64I core: detects program end
// by committed PC, samples gp as the result code, and enforces a cycle limit.
//
// state | meaning
// IDLE  | after reset, waiting for start; all outputs 0
// RUN   | program executing, cycle_cnt counting
// CHECK | end PC seen, evaluating latched gp
// DONE  | result valid and held until next start
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned           XLEN       = 64,
  parameter logic [XLEN-1:0]       END_PC     = XLEN'(DEF_END_PC),
  parameter int unsigned           MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned           CNT_W      = 32,
  parameter int unsigned           TALLY_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    gp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [XLEN-1:0]    err_code,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [TALLY_W-1:0] test_cnt,
  output logic [TALLY_W-1:0] pass_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  mon_state_e state;
  mon_state_e state_next;
  logic       pc_hit;
  logic       at_limit;
  logic       inc_test;
  logic       inc_pass;

  assign pc_hit   = (pc == END_PC);
  assign at_limit = (cycle_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC match takes priority over the limit, so a program ending on the last
  // allowed cycle still counts as a normal end.
  always_comb begin
    state_next = state;
    inc_test   = 1'b0;
    inc_pass   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (pc_hit) begin
          state_next = CHECK;
        end else if (at_limit) begin
          state_next = DONE;
          inc_test   = 1'b1;
        end
      end
      CHECK: begin
        state_next = DONE;
        inc_test   = 1'b1;
        inc_pass   = (err_code == '0);
      end
      DONE: begin
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      err_code  <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycle_cnt <= '0;
            err_code  <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        RUN: begin
          if (pc_hit) begin
            err_code <= gp;
          end else if (at_limit) begin
            timeout  <= 1'b1;
            err_code <= '0;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          pass <= (err_code == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy = is_busy(state);
  assign done = (state == DONE);

  sat_counter #(.W(TALLY_W)) u_test_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (inc_test),
    .count (test_cnt)
  );

  sat_counter #(.W(TALLY_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (inc_pass),
    .count (pass_cnt)
  );

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: directed and random program runs
// checked against a per-run outcome model, plus reset and tally saturation.
module tb_test_monitor;
  import test_monitor_pkg::*;

  localparam int unsigned MAXC = 16;
  localparam logic [63:0] ENDP = DEF_END_PC;
  localparam logic [63:0] IDLE_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] pc;
  logic [63:0] gp;
  logic        busy, done, pass, timeout;
  logic [63:0] err_code;
  logic [31:0] cycle_cnt;
  logic [7:0]  test_cnt, pass_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int test_m  = 0;
  int pass_m  = 0;

  logic [63:0] pc_seq [16];
  logic [63:0] gp_seq [16];

  test_monitor #(
    .XLEN(64), .END_PC(ENDP), .MAX_CYCLES(MAXC), .CNT_W(32), .TALLY_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .gp(gp),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_code(err_code), .cycle_cnt(cycle_cnt),
    .test_cnt(test_cnt), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_tmo"},  64'(timeout), 64'd0);
    check({tag, "_err"},  err_code, 64'd0);
    check({tag, "_cyc"},  64'(cycle_cnt), 64'd0);
    check({tag, "_tcnt"}, 64'(test_cnt), 64'd0);
    check({tag, "_pcnt"}, 64'(pass_cnt), 64'd0);
  endtask

  // Model: the run ends at the first cycle whose pc equals END_PC, provided it
  // happens within MAXC cycles; otherwise it times out on cycle MAXC-1.
  task automatic run_seq(input string tag, input int mid_start);
    int  k;
    bit  hit;
    bit  exp_pass;
    logic [63:0] exp_err;
    hit = 0;
    k   = MAXC - 1;
    for (int i = 0; i < MAXC; i++) begin
      if (!hit && pc_seq[i] == ENDP) begin
        hit = 1;
        k   = i;
      end
    end
    exp_err  = hit ? gp_seq[k] : 64'd0;
    exp_pass = hit && (gp_seq[k] == 64'd0);
    if (test_m < 255) test_m++;
    if (exp_pass && pass_m < 255) pass_m++;

    @(negedge clk);
    start = 1'b1;
    pc    = IDLE_PC;
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      check({tag, "_busy_run"}, 64'(busy), 64'd1);
      check({tag, "_done_run"}, 64'(done), 64'd0);
      check({tag, "_cyc_run"},  64'(cycle_cnt), 64'(c));
      if (c == 0) begin
        check({tag, "_pass_clr"}, 64'(pass), 64'd0);
        check({tag, "_tmo_clr"},  64'(timeout), 64'd0);
        check({tag, "_err_clr"},  err_code, 64'd0);
      end
      start = (c == mid_start);
      pc    = pc_seq[c];
      gp    = gp_seq[c];
    end
    @(negedge clk);
    start = 1'b0;
    pc    = IDLE_PC;
    gp    = 64'($urandom);
    if (hit) begin
      check({tag, "_busy_chk"}, 64'(busy), 64'd1);
      check({tag, "_done_chk"}, 64'(done), 64'd0);
      @(negedge clk);
    end
    check({tag, "_done"},    64'(done), 64'd1);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_pass"},    64'(pass), 64'(exp_pass));
    check({tag, "_timeout"}, 64'(timeout), 64'(!hit));
    check({tag, "_err"},     err_code, exp_err);
    check({tag, "_cyc"},     64'(cycle_cnt), 64'(k));
    check({tag, "_tcnt"},    64'(test_cnt), 64'(test_m));
    check({tag, "_pcnt"},    64'(pass_cnt), 64'(pass_m));
    @(negedge clk);
    check({tag, "_hold"},    64'({done, pass, timeout}), 64'({1'b1, exp_pass, !hit}));
  endtask

  task automatic fill_linear(input logic [63:0] end_gp);
    for (int i = 0; i < 16; i++) begin
      pc_seq[i] = (i < 8) ? 64'(i * 4) : IDLE_PC;
      gp_seq[i] = (i == 7) ? end_gp : 64'd0;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pc    = 64'd0;
    gp    = 64'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    fill_linear(64'd0);
    run_seq("lin_pass", -1);
    fill_linear(64'd5);
    run_seq("lin_fail", -1);

    for (int i = 0; i < 16; i++) begin
      pc_seq[i] = 64'h4;
      gp_seq[i] = 64'd7;
    end
    run_seq("timeout", -1);

    for (int i = 0; i < 16; i++) begin
      pc_seq[i] = (i == 15) ? ENDP : 64'h4;
      gp_seq[i] = (i == 15) ? 64'd0 : 64'd3;
    end
    run_seq("edge_pass", -1);

    fill_linear(64'd0);
    run_seq("b2b_pass1", 3);
    fill_linear(64'd9);
    run_seq("b2b_fail", 2);
    fill_linear(64'd0);
    run_seq("b2b_pass2", 5);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) begin
        pc_seq[i] = ($urandom_range(0, 9) == 0) ? ENDP : 64'($urandom_range(0, 15) * 4 + 32);
        gp_seq[i] = $urandom_range(0, 1) ? 64'd0 : 64'($urandom_range(1, 1000));
      end
      run_seq("rand", $urandom_range(1, 6));
    end

    // Reset in the middle of a run, with cycle_cnt at 3.
    @(negedge clk);
    start = 1'b1;
    pc    = IDLE_PC;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_cyc", 64'(cycle_cnt), 64'd3);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst    = 1'b0;
    test_m = 0;
    pass_m = 0;
    @(negedge clk);
    check_all_zero("post_rst");

    // Tally saturation: 260 immediate-end runs, every fourth one failing.
    for (int r = 0; r < 260; r++) begin
      for (int i = 0; i < 16; i++) begin
        pc_seq[i] = ENDP;
        gp_seq[i] = (r % 4 == 3) ? 64'd1 : 64'd0;
      end
      run_seq("sat", -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed time limit expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable run-control and result monitor that sits directly downstream of the RV64I `Top` core. It watches the committed PC and register x3 (gp) to decide when a test program has ended and whether it passed. It also enforces a cycle timeout and keeps running tallies across back-to-back programs. It replaces per-test wait/compare logic in benches, and is reusable on FPGA for self-checking runs.

## Interface
Parameters:
- `XLEN`, 64, data/PC width
- `END_PC`, 64'h0000001c, PC value that marks end of program
- `MAX_CYCLES`, 10000000, cycles allowed per run before timeout
- `CNT_W`, 32, width of cycle counter (must hold `MAX_CYCLES`)
- `TALLY_W`, 8, width of test/pass tallies

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; begins a run (core reset released externally in same cycle)
- `pc`  in  XLEN  core current_pc
- `gp`  in  XLEN  core register x3 value
- `busy`  out  1  run in progress (RUN or CHECK)
- `done`  out  1  result valid (DONE state)
- `pass`  out  1  run ended at `END_PC` with gp == 0
- `timeout`  out  1  run ended by cycle limit
- `err_code`  out  XLEN  gp value sampled at end (0 on timeout)
- `cycle_cnt`  out  CNT_W  cycles spent in RUN for current/last run
- `test_cnt`  out  TALLY_W  completed runs since reset, saturating
- `pass_cnt`  out  TALLY_W  passed runs since reset, saturating

## Operation
- States: IDLE, RUN, CHECK, DONE. Reset → IDLE.
- IDLE: all outputs 0. `start`=1 → RUN and `cycle_cnt` cleared to 0.
- RUN: `busy`=1. `cycle_cnt` increments by 1 each cycle.
  - `pc == END_PC` → latch `gp` into `err_code` and go to CHECK.
  - Else, if `cycle_cnt == MAX_CYCLES-1` → DONE with `timeout`=1, `err_code`=0.
  - A PC match in the same cycle as the limit wins: the run is treated as a normal end.
- CHECK: `busy`=1. Compute `pass = (err_code == 0)`. Increment `test_cnt`, and `pass_cnt` if passed. Go to DONE.
  - The timeout path also increments `test_cnt`, on its DONE entry.
- DONE: `done`=1. `pass`, `timeout`, `err_code` and `cycle_cnt` hold.
  - `start`=1 → RUN. This clears `cycle_cnt`, `pass`, `timeout` and `err_code`. Tallies are kept.
- `start` in RUN/CHECK is ignored.
- Tallies saturate at all-ones. `cycle_cnt` never exceeds `MAX_CYCLES-1`.
- `pass` and `timeout` are never both 1.

## Timing
- Match sampled in RUN at cycle k → CHECK at k+1 → `done`/`pass` visible from k+2.
- Timeout detected at cycle k → `done`=1, `timeout`=1 from k+1.
- `start` sampled on rising edge. The first RUN cycle shows `cycle_cnt`=0.
- All outputs are registered; there are no combinational input→output paths.
- Asserting `rst` at any time (including mid-RUN) immediately forces IDLE and zeroes every output and tally.

## Structure
- Shared package `test_monitor_pkg` holds:
  - the `mon_state_e` enum (IDLE, RUN, CHECK, DONE),
  - the default `END_PC` and `MAX_CYCLES` constants, shared with benches.
- One sub-module, `sat_counter`: a parameterized-width saturating incrementer with enable and clear. It is instantiated for `test_cnt` and `pass_cnt`.
- FSM, cycle counter and result registers live in `test_monitor`.

## Test plan
- Start; drive pc 0,4,8,…,0x1c with gp=0 → `done`=1 and `pass`=1 two cycles after pc=0x1c; `cycle_cnt`=7, `test_cnt`=1, `pass_cnt`=1.
- Same sequence with gp=5 at the 0x1c cycle → `pass`=0, `err_code`=5, `test_cnt`=1, `pass_cnt`=0.
- `MAX_CYCLES`=16, pc held at 0x4 → `timeout`=1 at cycle 16, `cycle_cnt`=15, `err_code`=0, `pass`=0.
- `MAX_CYCLES`=16, pc=0x1c exactly at `cycle_cnt`=15 with gp=0 → `pass`=1, `timeout`=0.
- Three back-to-back runs (pass, fail, pass) restarted via `start` from DONE → `test_cnt`=3, `pass_cnt`=2. `start` pulsed mid-RUN has no effect.
- `rst` asserted mid-RUN at `cycle_cnt`=3 → IDLE; all outputs and tallies 0 before the next clock edge.
